fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_sequencer_wait_timer.sv | 31 +++
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer:
// state codes and mux select constants.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_VECTOR = 3'd1,
    ST_MAR    = 3'd2,
    ST_READ   = 3'd3,
    ST_IR     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam int PC_SRC_RESET_VEC = 2;
  localparam int ADDR_SRC_PC      = 0;

  function automatic logic is_read(
    input state_t s
  );
    return (s == ST_READ);
  endfunction

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// wait_timer: counts READ cycles for the memory timeout.
// Ports: clk_i, reset_i, clear_i, enable_i, expired_o.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [W-1:0] LAST = W'(WAIT_MAX - 1);

  logic [W-1:0] r_count;
  logic         w_expired;

  // Expired marks the WAIT_MAX-th cycle of the current wait.
  assign w_expired = (r_count == LAST);
  assign expired_o = w_expired;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_count <= '0;
    end else if (enable_i && !w_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Moore FSM driving the PC/MAR/IR strobes of an instruction fetch.
// Ports: clk_i, reset_i (sync, high), halt_i, mem_ready_i in;
// active-low strobes, mux selects, mem_rd_o, fetch_done_o,
// fault_o, state_o out. Optional FETCH_COUNT_EN adds fetch_count_o.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2,
  parameter int WAIT_MAX         = 15
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        halt_i,
  input  logic                        mem_ready_i,
  output logic                        pc_reset_no,
  output logic                        mar_reset_no,
  output logic                        pc_ld_no,
  output logic                        pc_inc_no,
  output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
  output logic [ADDR_SELECT_SIZE-1:0] addr_src_o,
  output logic                        mar_ld_no,
  output logic                        ir_ld_no,
  output logic                        mem_rd_o,
  output logic                        fetch_done_o,
  output logic                        fault_o,
`ifdef FETCH_COUNT_EN
  output logic [2:0]                  state_o,
  output logic [15:0]                 fetch_count_o
`else
  output logic [2:0]                  state_o
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_in_read;
  logic   w_expired;

  assign w_in_read = is_read(r_state);

  // Counter sits at zero whenever we are outside READ,
  // so it always starts from zero on entry.
  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (!w_in_read),
    .enable_i  (w_in_read),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RESET:  w_next = ST_VECTOR;
      ST_VECTOR: w_next = ST_MAR;
      ST_MAR:    w_next = ST_READ;
      // Ready on the last allowed cycle beats the timeout.
      ST_READ: begin
        if (mem_ready_i) begin
          w_next = ST_IR;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end else begin
          w_next = ST_READ;
        end
      end
      ST_IR:    w_next = halt_i ? ST_HALT : ST_MAR;
      ST_HALT:  w_next = halt_i ? ST_HALT : ST_MAR;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_RESET;
    endcase
  end

  always_comb begin
    pc_reset_no  = 1'b1;
    mar_reset_no = 1'b1;
    pc_ld_no     = 1'b1;
    pc_inc_no    = 1'b1;
    pc_src_o     = '0;
    addr_src_o   = '0;
    mar_ld_no    = 1'b1;
    ir_ld_no     = 1'b1;
    mem_rd_o     = 1'b0;
    fetch_done_o = 1'b0;
    fault_o      = 1'b0;
    unique case (r_state)
      ST_RESET: begin
        pc_reset_no  = 1'b0;
        mar_reset_no = 1'b0;
      end
      ST_VECTOR: begin
        pc_src_o = PC_SELECT_SIZE'(PC_SRC_RESET_VEC);
        pc_ld_no = 1'b0;
      end
      ST_MAR: begin
        addr_src_o = ADDR_SELECT_SIZE'(ADDR_SRC_PC);
        mar_ld_no  = 1'b0;
      end
      ST_READ: begin
        mem_rd_o = 1'b1;
      end
      ST_IR: begin
        ir_ld_no     = 1'b0;
        pc_inc_no    = 1'b0;
        fetch_done_o = 1'b1;
      end
      ST_FAULT: begin
        fault_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_o = r_state;

`ifdef FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fetch_count <= '0;
    end else if (r_state == ST_IR) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an expected-state
// scoreboard queue and a per-state output table.
module tb_fetch_sequencer;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_VECTOR = 3'd1;
  localparam logic [2:0] S_MAR    = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_IR     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       halt_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_reset_no;
  logic       mar_reset_no;
  logic       pc_ld_no;
  logic       pc_inc_no;
  logic [2:0] pc_src_o;
  logic [1:0] addr_src_o;
  logic       mar_ld_no;
  logic       ir_ld_no;
  logic       mem_rd_o;
  logic       fetch_done_o;
  logic       fault_o;
  logic [2:0] state_o;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_o;
  logic [15:0] exp_cnt = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];

  fetch_sequencer #(
    .PC_SELECT_SIZE   (3),
    .ADDR_SELECT_SIZE (2),
    .WAIT_MAX         (15)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .halt_i       (halt_i),
    .mem_ready_i  (mem_ready_i),
    .pc_reset_no  (pc_reset_no),
    .mar_reset_no (mar_reset_no),
    .pc_ld_no     (pc_ld_no),
    .pc_inc_no    (pc_inc_no),
    .pc_src_o     (pc_src_o),
    .addr_src_o   (addr_src_o),
    .mar_ld_no    (mar_ld_no),
    .ir_ld_no     (ir_ld_no),
    .mem_rd_o     (mem_rd_o),
    .fetch_done_o (fetch_done_o),
    .fault_o      (fault_o),
`ifdef FETCH_COUNT_EN
    .state_o      (state_o),
    .fetch_count_o(fetch_count_o)
`else
    .state_o      (state_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // {pc_rst_n, mar_rst_n, pc_ld_n, pc_inc_n, pc_src,
  //  addr_src, mar_ld_n, ir_ld_n, rd, done, fault}
  function automatic logic [13:0] exp_out(input logic [2:0] s);
    logic [13:0] v;
    v = {1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 2'd0,
         1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    case (s)
      S_RESET:  begin v[13] = 1'b0; v[12] = 1'b0; end
      S_VECTOR: begin v[11] = 1'b0; v[9:7] = 3'd2; end
      S_MAR:    begin v[6:5] = 2'd0; v[4] = 1'b0; end
      S_READ:   v[2] = 1'b1;
      S_IR:     begin v[3] = 1'b0; v[10] = 1'b0; v[1] = 1'b1; end
      S_FAULT:  v[0] = 1'b1;
      default:  ;
    endcase
    return v;
  endfunction

  task automatic check_pop();
    logic [2:0]  e;
    logic [13:0] got;
    logic [13:0] want;
    e = sb.pop_front();
    got = {pc_reset_no, mar_reset_no, pc_ld_no, pc_inc_no,
           pc_src_o, addr_src_o, mar_ld_no, ir_ld_no,
           mem_rd_o, fetch_done_o, fault_o};
    want = exp_out(e);
    checks++;
    assert (state_o === e) else begin
      errors++;
      $error("FAIL state: got %0d want %0d", state_o, e);
    end
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL outputs(st %0d): got %b want %b",
             e, got, want);
    end
    checks++;
    assert (!(pc_ld_no === 1'b0 && pc_inc_no === 1'b0)) else begin
      errors++;
      $error("FAIL pc_ld_inc: got %b%b want not 00",
             pc_ld_no, pc_inc_no);
    end
`ifdef FETCH_COUNT_EN
    if (e == S_RESET) exp_cnt = '0;
    checks++;
    assert (fetch_count_o === exp_cnt) else begin
      errors++;
      $error("FAIL fetch_count: got %0d want %0d",
             fetch_count_o, exp_cnt);
    end
    if (e == S_IR) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic step(input logic rst, input logic hlt,
                      input logic rdy, input logic [2:0] st);
    reset_i = rst;
    halt_i = hlt;
    mem_ready_i = rdy;
    sb.push_back(st);
    @(posedge clk_i);
    #1;
    check_pop();
  endtask

  initial begin
    // Reset one cycle, ready tied high.
    step(1, 0, 1, S_RESET);
    step(0, 0, 1, S_VECTOR);
    step(0, 0, 1, S_MAR);
    step(0, 0, 1, S_READ);
    step(0, 0, 1, S_IR);
    step(0, 0, 1, S_MAR);
    step(0, 0, 1, S_READ);
    step(0, 0, 1, S_IR);
    // Ready delayed 4 cycles.
    step(0, 0, 0, S_MAR);
    step(0, 0, 0, S_READ);
    for (int i = 0; i < 4; i++) step(0, 0, 0, S_READ);
    step(0, 0, 1, S_IR);
    // Ready arriving on the 15th READ cycle wins.
    step(0, 0, 0, S_MAR);
    step(0, 0, 0, S_READ);
    for (int i = 0; i < 14; i++) step(0, 0, 0, S_READ);
    step(0, 0, 1, S_IR);
    // Halt raised during READ finishes the fetch first.
    step(0, 0, 0, S_MAR);
    step(0, 1, 0, S_READ);
    step(0, 1, 0, S_READ);
    step(0, 1, 1, S_IR);
    step(0, 1, 1, S_HALT);
    step(0, 1, 1, S_HALT);
    step(0, 0, 1, S_MAR);
    step(0, 0, 1, S_READ);
    step(0, 0, 1, S_IR);
    // Timeout after 15 READ cycles; fault is sticky.
    step(0, 0, 0, S_MAR);
    step(0, 0, 0, S_READ);
    for (int i = 0; i < 14; i++) step(0, 0, 0, S_READ);
    step(0, 0, 0, S_FAULT);
    step(0, 0, 1, S_FAULT);
    step(0, 1, 1, S_FAULT);
    // Reset from FAULT, then reset mid-READ.
    step(1, 0, 1, S_RESET);
    step(0, 0, 1, S_VECTOR);
    step(0, 0, 0, S_MAR);
    step(0, 0, 0, S_READ);
    step(0, 0, 0, S_READ);
    step(1, 0, 1, S_RESET);
    step(0, 0, 1, S_VECTOR);
    step(0, 0, 1, S_MAR);
    step(0, 0, 1, S_READ);
    step(0, 0, 1, S_IR);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
